// File: rtl/score_drawer_pkg.sv
// Shared definitions for the score glyph drawer.
// Contents: FSM state encoding, glyph box size, VGA coordinate widths and
// double-dabble helpers used by the BCD converter.
package score_drawer_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CONV  = 3'd1,
      DRAW  = 3'd2,
      FLUSH = 3'd3,
      FIN   = 3'd4
   } state_t;

   localparam int GLYPH_W   = 16;
   localparam int GLYPH_H   = 32;
   localparam int VGA_X_W   = 8;
   localparam int VGA_Y_W   = 7;
   localparam int VGA_X_MAX = 160;
   localparam int VGA_Y_MAX = 120;

   // Double-dabble correction: a nibble of 5 or more would carry past 9 after the shift.
   function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
      return (nib >= 4'd5) ? (nib + 4'd3) : nib;
   endfunction

   // Largest value representable in n decimal digits (10^n - 1).
   function automatic int unsigned bcd_max(input int unsigned n);
      int unsigned v;
      v = 32'd1;
      for (int unsigned k = 0; k < n; k++) begin
         v = v * 32'd10;
      end
      return v - 32'd1;
   endfunction

endpackage

// File: rtl/score_drawer_if.sv
// Bus bundle between game logic / glyph reader / VGA adapter and score_drawer.
// slave  : the drawer's view (start, score, glyph_colour in; the rest out).
// master : the surrounding logic's view (mirror of slave).
interface score_drawer_if #(
   parameter int SCORE_W = 14
);
   logic               start;
   logic [SCORE_W-1:0] score;
   logic               busy;
   logic               done;
   logic [4:0]         glyph_id;
   logic [3:0]         glyph_i;
   logic [7:0]         glyph_j;
   logic [14:0]        glyph_colour;
   logic [7:0]         x;
   logic [6:0]         y;
   logic [14:0]        colour;
   logic               plot;

   modport slave (
      input  start, score, glyph_colour,
      output busy, done, glyph_id, glyph_i, glyph_j, x, y, colour, plot
   );

   modport master (
      output start, score, glyph_colour,
      input  busy, done, glyph_id, glyph_i, glyph_j, x, y, colour, plot
   );
endinterface

// File: rtl/score_drawer_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one shift per clock).
// Ports: clock, reset (async, high); start loads score and clears the BCD
// registers; digits holds NUM_DIGITS nibbles, MSD in the top nibble; valid
// rises after exactly SCORE_W shifts and stays high until the next start.
// Scores above 10^NUM_DIGITS-1 come out as all nines.
module bin2bcd_seq
   import score_drawer_pkg::*;
#(
   parameter int SCORE_W    = 14,
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [SCORE_W-1:0]      score,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic                    valid
);
   localparam int          BCD_W     = 4 * NUM_DIGITS;
   localparam int          CNT_W     = $clog2(SCORE_W + 1);
   localparam int unsigned SAT_LIMIT = bcd_max(NUM_DIGITS);

   logic [SCORE_W-1:0] bin_r;
   logic [BCD_W-1:0]   bcd_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               run_r;
   logic               sat_r;
   logic               valid_r;
   logic               sat_s;

   // One double-dabble step: adjust every nibble, then shift in the next binary bit.
   function automatic logic [BCD_W-1:0] dd_shift(input logic [BCD_W-1:0] bcd, input logic bit_in);
      logic [BCD_W-1:0] a;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         a[4*k +: 4] = dd_adjust(bcd[4*k +: 4]);
      end
      return {a[BCD_W-2:0], bit_in};
   endfunction

   assign sat_s = (32'(score) > SAT_LIMIT);

   // Load on start, then shift SCORE_W times; overflowed scores saturate on the last shift.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bin_r   <= '0;
         bcd_r   <= '0;
         cnt_r   <= '0;
         run_r   <= 1'b0;
         sat_r   <= 1'b0;
         valid_r <= 1'b0;
      end else if (start) begin
         bin_r   <= score;
         bcd_r   <= '0;
         cnt_r   <= '0;
         run_r   <= 1'b1;
         sat_r   <= sat_s;
         valid_r <= 1'b0;
      end else if (run_r) begin
         bcd_r <= dd_shift(bcd_r, bin_r[SCORE_W-1]);
         bin_r <= {bin_r[SCORE_W-2:0], 1'b0};
         cnt_r <= cnt_r + CNT_W'(1);
         if (cnt_r == CNT_W'(SCORE_W - 1)) begin
            run_r   <= 1'b0;
            valid_r <= 1'b1;
            if (sat_r) begin
               bcd_r <= {NUM_DIGITS{4'd9}};
            end
         end
      end
   end

   assign digits = bcd_r;
   assign valid  = valid_r;
endmodule

// File: rtl/score_drawer.sv
// Score drawer: latches a binary score, converts it to decimal and sweeps
// every pixel of each digit glyph through an external glyph ROM reader,
// re-timing the returned colour against its screen coordinates.
// Ports: clock, reset (async, high); bus (score_drawer_if.slave) carries
// start/score/busy/done, the glyph address (glyph_id/i/j) and returned
// glyph_colour, and the VGA plot outputs x/y/colour/plot.
module score_drawer
   import score_drawer_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCORE_W    = 14,
   parameter int ORIGIN_X   = 96,
   parameter int ORIGIN_Y   = 4,
   parameter int ROM_LAT    = 1
) (
   input logic           clock,
   input logic           reset,
   score_drawer_if.slave bus
);
   localparam int DW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BCD_W     = 4 * NUM_DIGITS;
   // ROM_LAT pipeline stages plus the output register must drain before done.
   localparam int FLUSH_LEN = ROM_LAT + 1;
   localparam int FW        = $clog2(FLUSH_LEN + 1);

   generate
      if ((ORIGIN_X + NUM_DIGITS * GLYPH_W > VGA_X_MAX) || (ORIGIN_Y + GLYPH_H > VGA_Y_MAX) || (ROM_LAT < 1)) begin : g_bad_params
         $error("score_drawer: glyph box leaves the screen or ROM_LAT < 1");
      end
   endgenerate

   state_t             state_r, state_nxt_s;
   logic               bcd_start_s, bcd_valid_s;
   logic [BCD_W-1:0]   digits_s;
   logic               last_addr_s, addr_load_s;
   logic [DW-1:0]      d_r, d_nxt_s;
   logic [3:0]         i_r, i_nxt_s;
   logic [7:0]         j_r, j_nxt_s;
   logic [4:0]         id_r;
   logic [FW-1:0]      flush_r;
   logic               pv_r [ROM_LAT];
   logic [VGA_X_W-1:0] px_r [ROM_LAT];
   logic [VGA_Y_W-1:0] py_r [ROM_LAT];
   logic [VGA_X_W-1:0] x_r;
   logic [VGA_Y_W-1:0] y_r;
   logic [14:0]        colour_r;
   logic               plot_r, busy_r, done_r;

   // Coordinates are formed at 9 bits and truncated to the VGA width.
   function automatic logic [VGA_X_W-1:0] screen_x(input logic [DW-1:0] d, input logic [3:0] i);
      logic [8:0] t;
      t = 9'(ORIGIN_X) + 9'(d) * 9'(GLYPH_W) + 9'(i);
      return t[VGA_X_W-1:0];
   endfunction

   function automatic logic [VGA_Y_W-1:0] screen_y(input logic [7:0] j);
      logic [8:0] t;
      t = 9'(ORIGIN_Y) + 9'(j);
      return t[VGA_Y_W-1:0];
   endfunction

   // Digit d=0 is the most-significant nibble.
   function automatic logic [4:0] id_of(input logic [BCD_W-1:0] dg, input logic [DW-1:0] d);
      return {1'b0, dg[(NUM_DIGITS - 1 - int'(d)) * 4 +: 4]};
   endfunction

   assign bcd_start_s = (state_r == IDLE) && bus.start;

   bin2bcd_seq #(.SCORE_W(SCORE_W), .NUM_DIGITS(NUM_DIGITS)) u_bcd (
      .clock  (clock),
      .reset  (reset),
      .start  (bcd_start_s),
      .score  (bus.score),
      .digits (digits_s),
      .valid  (bcd_valid_s)
   );

   assign last_addr_s = (d_r == DW'(NUM_DIGITS - 1)) && (j_r == 8'(GLYPH_H - 1)) && (i_r == 4'(GLYPH_W - 1));
   assign addr_load_s = ((state_r == CONV) && bcd_valid_s) || ((state_r == DRAW) && !last_addr_s);

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE:    if (bus.start) state_nxt_s = CONV;  else state_nxt_s = IDLE;
         CONV:    if (bcd_valid_s) state_nxt_s = DRAW; else state_nxt_s = CONV;
         DRAW:    if (last_addr_s) state_nxt_s = FLUSH; else state_nxt_s = DRAW;
         FLUSH:   if (flush_r == FW'(FLUSH_LEN - 1)) state_nxt_s = FIN; else state_nxt_s = FLUSH;
         FIN:     state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Next glyph address: i innermost, then j, then digit; CONV starts the sweep at zero.
   always_comb begin
      d_nxt_s = d_r;
      i_nxt_s = i_r;
      j_nxt_s = j_r;
      if (state_r == CONV) begin
         d_nxt_s = '0;
         i_nxt_s = 4'd0;
         j_nxt_s = 8'd0;
      end else if (i_r == 4'(GLYPH_W - 1)) begin
         i_nxt_s = 4'd0;
         if (j_r == 8'(GLYPH_H - 1)) begin
            j_nxt_s = 8'd0;
            d_nxt_s = d_r + DW'(1);
         end else begin
            j_nxt_s = j_r + 8'd1;
         end
      end else begin
         i_nxt_s = i_r + 4'd1;
      end
   end

   // State register plus registered busy/done decoded from the next state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s == CONV) || (state_nxt_s == DRAW) || (state_nxt_s == FLUSH);
         done_r  <= (state_nxt_s == FIN);
      end
   end

   // Glyph address registers; glyph_id follows the digit index being loaded.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         d_r  <= '0;
         i_r  <= 4'd0;
         j_r  <= 8'd0;
         id_r <= 5'd0;
      end else if (addr_load_s) begin
         d_r  <= d_nxt_s;
         i_r  <= i_nxt_s;
         j_r  <= j_nxt_s;
         id_r <= id_of(digits_s, d_nxt_s);
      end
   end

   // Counts clocks spent in FLUSH.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         flush_r <= '0;
      end else if (state_r == FLUSH) begin
         flush_r <= flush_r + FW'(1);
      end else begin
         flush_r <= '0;
      end
   end

   // Coordinate/valid delay line matching the glyph ROM latency.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < ROM_LAT; k++) begin
            pv_r[k] <= 1'b0;
            px_r[k] <= '0;
            py_r[k] <= '0;
         end
      end else begin
         pv_r[0] <= (state_r == DRAW);
         px_r[0] <= screen_x(d_r, i_r);
         py_r[0] <= screen_y(j_r);
         for (int k = 1; k < ROM_LAT; k++) begin
            pv_r[k] <= pv_r[k-1];
            px_r[k] <= px_r[k-1];
            py_r[k] <= py_r[k-1];
         end
      end
   end

   // Output register: x/y/colour update only with a plot so they hold between frames.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         plot_r   <= 1'b0;
         x_r      <= '0;
         y_r      <= '0;
         colour_r <= 15'd0;
      end else begin
         plot_r <= pv_r[ROM_LAT-1];
         if (pv_r[ROM_LAT-1]) begin
            x_r      <= px_r[ROM_LAT-1];
            y_r      <= py_r[ROM_LAT-1];
            colour_r <= bus.glyph_colour;
         end
      end
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.glyph_id = id_r;
   assign bus.glyph_i  = i_r;
   assign bus.glyph_j  = j_r;
   assign bus.x        = x_r;
   assign bus.y        = y_r;
   assign bus.colour   = colour_r;
   assign bus.plot     = plot_r;
endmodule

// File: tb/tb_score_drawer.sv
// Self-checking bench for score_drawer: two instances (ROM_LAT=1 and 2) are
// driven with the same requests; each has its own registered model glyph
// reader returning a hash of (id,i,j) and a monitor comparing every plot with
// the pixel order and digits computed from the score by plain arithmetic.
module tb_score_drawer;
   import score_drawer_pkg::*;

   localparam int N   = 4;
   localparam int SW  = 14;
   localparam int OX  = 96;
   localparam int OY  = 4;
   localparam int PIX = N * GLYPH_W * GLYPH_H;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start_s = 1'b0;
   logic [SW-1:0] score_s = '0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int accept_cyc = 0;
   int exp_dig [N];
   int plots [2], bad [2], done_cnt [2], done_cyc [2];
   int first_x [2], first_y [2], first_c [2], last_x [2], last_y [2], last_cyc [2];
   logic busy_w [2], plot_w [2], done_w [2];

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic int ghash(int id, int i, int j);
      return ((id * 2731) ^ (i * 97) ^ (j * 613) ^ 21) & 32'h7fff;
   endfunction

   function automatic int pow10(int n);
      int v = 1;
      for (int k = 0; k < n; k++) v = v * 10;
      return v;
   endfunction

   task automatic check_eq(string tag, int got, int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   genvar g;
   generate
      for (g = 0; g < 2; g++) begin : g_dut
         localparam int RL = g + 1;
         score_drawer_if #(.SCORE_W(SW)) bus ();
         logic [14:0] rom_r [2];

         assign bus.start        = start_s;
         assign bus.score        = score_s;
         assign bus.glyph_colour = rom_r[RL-1];
         assign busy_w[g]        = bus.busy;
         assign plot_w[g]        = bus.plot;
         assign done_w[g]        = bus.done;

         // model glyph reader with RL register stages
         always @(posedge clock) begin
            rom_r[0] <= 15'(ghash(int'(bus.glyph_id), int'(bus.glyph_i), int'(bus.glyph_j)));
            rom_r[1] <= rom_r[0];
         end

         score_drawer #(.NUM_DIGITS(N), .SCORE_W(SW), .ORIGIN_X(OX), .ORIGIN_Y(OY), .ROM_LAT(RL)) dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus)
         );

         // plot monitor against the pixel-order model
         always @(negedge clock) begin
            int p, ed, ei, ej, ex, ey, ec;
            if (!reset) begin
               if (bus.plot) begin
                  p  = plots[g];
                  ed = p / (GLYPH_W * GLYPH_H);
                  ej = (p / GLYPH_W) % GLYPH_H;
                  ei = p % GLYPH_W;
                  ex = OX + ed * GLYPH_W + ei;
                  ey = OY + ej;
                  if (p >= PIX) bad[g]++;
                  else begin
                     ec = ghash(exp_dig[ed], ei, ej);
                     if (int'(bus.x) != ex || int'(bus.y) != ey || int'(bus.colour) != ec) bad[g]++;
                  end
                  if (p > 0 && cyc != last_cyc[g] + 1) bad[g]++;
                  if (!bus.busy) bad[g]++;
                  if (p == 0) begin
                     first_x[g] = int'(bus.x);
                     first_y[g] = int'(bus.y);
                     first_c[g] = int'(bus.colour);
                  end
                  last_x[g]   = int'(bus.x);
                  last_y[g]   = int'(bus.y);
                  last_cyc[g] = cyc;
                  plots[g]++;
               end
               if (bus.done) begin
                  done_cnt[g]++;
                  done_cyc[g] = cyc;
               end
            end
         end
      end
   endgenerate

   task automatic prepare(int s);
      int sat;
      sat = (s > 9999) ? 9999 : s;
      for (int d = 0; d < N; d++) exp_dig[d] = (sat / pow10(N - 1 - d)) % 10;
      for (int k = 0; k < 2; k++) begin
         plots[k] = 0; bad[k] = 0; done_cnt[k] = 0; done_cyc[k] = 0;
         first_x[k] = -1; first_y[k] = -1; first_c[k] = -1; last_x[k] = -1; last_y[k] = -1;
      end
   endtask

   task automatic issue_start(int s);
      @(negedge clock);
      start_s = 1'b1;
      score_s = SW'(s);
      @(negedge clock);
      start_s = 1'b0;
      accept_cyc = cyc;
   endtask

   task automatic run_frame(string tag, int s, bit disturb);
      prepare(s);
      issue_start(s);
      check_eq($sformatf("%s_busy_on", tag), int'(busy_w[0]), 1);
      if (disturb) begin
         repeat (600) @(negedge clock);
         score_s = ~score_s;
         start_s = 1'b1;
         @(negedge clock);
         start_s = 1'b0;
      end
      for (int t = 0; t < 3000 && (done_cnt[0] == 0 || done_cnt[1] == 0); t++) begin
         @(negedge clock);
         #1;
      end
      repeat (20) @(negedge clock);
      for (int k = 0; k < 2; k++) begin
         check_eq($sformatf("%s_plots%0d", tag, k), plots[k], PIX);
         check_eq($sformatf("%s_badpix%0d", tag, k), bad[k], 0);
         check_eq($sformatf("%s_dones%0d", tag, k), done_cnt[k], 1);
         check_eq($sformatf("%s_latency%0d", tag, k), done_cyc[k] - accept_cyc, SW + PIX + (k + 1) + 2);
         check_eq($sformatf("%s_first_x%0d", tag, k), first_x[k], OX);
         check_eq($sformatf("%s_first_y%0d", tag, k), first_y[k], OY);
         check_eq($sformatf("%s_first_c%0d", tag, k), first_c[k], ghash(exp_dig[0], 0, 0));
         check_eq($sformatf("%s_last_x%0d", tag, k), last_x[k], OX + N * GLYPH_W - 1);
         check_eq($sformatf("%s_last_y%0d", tag, k), last_y[k], OY + GLYPH_H - 1);
         check_eq($sformatf("%s_idle%0d", tag, k), int'(busy_w[k]), 0);
      end
   endtask

   initial begin
      int s;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_eq("rst_busy", int'(g_dut[0].bus.busy), 0);
      check_eq("rst_done", int'(g_dut[0].bus.done), 0);
      check_eq("rst_plot", int'(g_dut[0].bus.plot), 0);
      check_eq("rst_x", int'(g_dut[0].bus.x), 0);
      check_eq("rst_y", int'(g_dut[0].bus.y), 0);
      check_eq("rst_colour", int'(g_dut[0].bus.colour), 0);
      check_eq("rst_gid", int'(g_dut[0].bus.glyph_id), 0);
      check_eq("rst_gi", int'(g_dut[0].bus.glyph_i), 0);
      check_eq("rst_gj", int'(g_dut[0].bus.glyph_j), 0);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      run_frame("f1234", 1234, 1'b0);
      run_frame("fzero", 0, 1'b0);
      run_frame("fsat", 12000, 1'b0);
      run_frame("fbusy", int'($urandom_range(0, 9999)), 1'b1);

      // reset in the middle of a sweep
      s = int'($urandom_range(0, 16383));
      prepare(s);
      issue_start(s);
      for (int t = 0; t < 3000 && plots[0] < 700; t++) begin
         @(negedge clock);
         #1;
      end
      check_eq("rst_mid_reached", plots[0], 700);
      reset = 1'b1;
      #1;
      check_eq("rst_mid_plot0", int'(plot_w[0]), 0);
      check_eq("rst_mid_busy0", int'(busy_w[0]), 0);
      check_eq("rst_mid_plot1", int'(plot_w[1]), 0);
      check_eq("rst_mid_busy1", int'(busy_w[1]), 0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (30) @(negedge clock);
      check_eq("rst_mid_nodone0", done_cnt[0], 0);
      check_eq("rst_mid_nodone1", done_cnt[1], 0);
      check_eq("rst_mid_done_low", int'(done_w[0]), 0);

      run_frame("fpost", int'($urandom_range(0, 16383)), 1'b0);
      for (int r = 0; r < 3; r++) begin
         run_frame($sformatf("frand%0d", r), int'($urandom_range(0, 16383)), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
